serial_flow_cmp: RTL

Parametrised serial flow processor: accepts two LSB-first serial bit streams in words of WIDTH bits and, per word, either adds them serially or compares them. It is the next generation of the fixed-width serial comparator FSM, adding:
- configurable word length
- a valid/start-of-word handshake with stall support
- selectable modes
- framing-error detection
- a word counter

It sits between serial line receivers and the downstream status/ATPG observation logic.

---
 rtl/serial_flow_cmp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/serial_flow_cmp.sv
// Serial LSB-first word processor: per word either adds two bit streams or
// compares them (equal / greater / less), with framing and a completed-word count.
module serial_flow_cmp #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             in_valid,
    input  logic             sof,
    input  logic             line_a,
    input  logic             line_b,
    input  logic [1:0]       mode,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done,
    output logic             result,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_EQ  = 2'b01;
    localparam logic [1:0] MODE_GT  = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    // Inequality is accumulated instead of equality so every accumulator clears to 0.
    logic             ne_q, ne_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic             accept, start, last;
    logic [1:0]       mode_cur;
    logic [IDX_W-1:0] idx_cur;
    logic             carry_in, ne_in, gt_in, lt_in;
    logic             diff, sum_bit, carry_out, ne_new, gt_new, lt_new;

    always_comb begin
        accept    = in_valid & ((state_q == ST_RUN) | sof);
        start     = accept & sof;

        // A sof bit starts from a clean word, whatever state the previous one left.
        mode_cur  = start ? mode : mode_q;
        idx_cur   = start ? '0 : idx_q;
        carry_in  = start ? 1'b0 : carry_q;
        ne_in     = start ? 1'b0 : ne_q;
        gt_in     = start ? 1'b0 : gt_q;
        lt_in     = start ? 1'b0 : lt_q;

        diff      = line_a ^ line_b;
        sum_bit   = diff ^ carry_in;
        carry_out = (line_a & line_b) | (carry_in & diff);
        ne_new    = ne_in | diff;
        gt_new    = (line_a & ~line_b) | (~diff & gt_in);
        lt_new    = (~line_a & line_b) | (~diff & lt_in);

        last      = accept && (idx_cur == IDX_W'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        ne_d        = ne_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        word_cnt_d  = word_cnt_q;

        out_valid_d = accept;
        out_bit_d   = 1'b0;
        done_d      = last;
        frame_err_d = start & (state_q == ST_RUN);

        if (accept) begin
            out_bit_d = (mode_cur == MODE_ADD) ? sum_bit : diff;
            mode_d    = mode_cur;
            idx_d     = idx_cur + IDX_W'(1);
            carry_d   = carry_out;
            ne_d      = ne_new;
            gt_d      = gt_new;
            lt_d      = lt_new;
            state_d   = last ? ST_IDLE : ST_RUN;
        end

        if (last) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            overflow_d = (mode_cur == MODE_ADD) ? carry_out : 1'b0;
            case (mode_cur)
                MODE_ADD: result_d = 1'b0;
                MODE_EQ:  result_d = ~ne_new;
                MODE_GT:  result_d = gt_new;
                default:  result_d = lt_new;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            mode_q      <= '0;
            carry_q     <= 1'b0;
            ne_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            ne_q        <= ne_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign word_cnt  = word_cnt_q;

endmodule
